// File: rtl/l2_arb_pkg.sv
// Shared types and limits for the L2 arbiter slice: FSM state encoding,
// maximum client count and a grant-index width helper.
package l2_arb_pkg;

    localparam int unsigned MAX_PORTS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of upstream client and downstream L2 signals around the arbiter.
// slave is the arbiter's view; master is the clients-plus-L2 environment.
interface l2_arbiter_if
    import l2_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 256
);
    localparam int unsigned IDX_W = idx_width(NUM_PORTS);

    logic [NUM_PORTS-1:0]             req_read;
    logic [NUM_PORTS-1:0]             req_write;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][LINE_W-1:0] req_wdata;
    logic [LINE_W-1:0]                req_rdata;
    logic [NUM_PORTS-1:0]             req_resp;
    logic                             down_read;
    logic                             down_write;
    logic [ADDR_W-1:0]                down_addr;
    logic [LINE_W-1:0]                down_wdata;
    logic [LINE_W-1:0]                down_rdata;
    logic                             down_resp;
    logic [IDX_W-1:0]                 grant_id;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, down_rdata, down_resp,
        output req_rdata, req_resp, down_read, down_write, down_addr, down_wdata, grant_id
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata, down_rdata, down_resp,
        input  req_rdata, req_resp, down_read, down_write, down_addr, down_wdata, grant_id
    );

endinterface

// File: rtl/l2_arbiter_rr_picker.sv
// Winner selection: first set request at or after ptr_i, wrapping to index 0.
// With ptr_i tied to zero this degenerates to lowest-index-wins priority.
module rr_picker #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // First pass covers ports at or above the pointer, second pass the wrap.
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (!valid_o && req_i[i] && (i >= int'(ptr_i))) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Multi-client L2 line arbiter with one outstanding downstream transaction.
// Define L2_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 256
) (
    input logic         clk,
    input logic         rst,
    l2_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
        $error("l2_arbiter: NUM_PORTS out of range");
    end

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic              down_read_q, down_read_d;
    logic              down_write_q, down_write_d;
    logic [ADDR_W-1:0] down_addr_q, down_addr_d;
    logic [LINE_W-1:0] down_wdata_q, down_wdata_d;

    logic [NUM_PORTS-1:0] req_any;
    logic [NUM_PORTS-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     pick_ptr;
    logic                 pick_valid;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LINE_W-1:0]    sel_wdata;
    logic                 sel_write;

    assign req_any = bus.req_read | bus.req_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;
`else
    assign pick_ptr = '0;
`endif

    rr_picker #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req_i  (req_any),
        .ptr_i  (pick_ptr),
        .gnt_o  (pick_oh),
        .idx_o  (pick_idx),
        .valid_o(pick_valid)
    );

    // One-hot AND-OR mux of the winner's payload; read+write counts as write.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = |(pick_oh & bus.req_write);
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (pick_oh[i]) begin
                sel_addr  = sel_addr | bus.req_addr[i];
                sel_wdata = sel_wdata | bus.req_wdata[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        down_read_d  = down_read_q;
        down_write_d = down_write_q;
        down_addr_d  = down_addr_q;
        down_wdata_d = down_wdata_q;
`ifdef L2_ARB_ROUND_ROBIN_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = BUSY;
                    grant_id_d   = pick_idx;
                    down_addr_d  = sel_addr;
                    down_wdata_d = sel_wdata;
                    down_read_d  = !sel_write;
                    down_write_d = sel_write;
                end
            end
            BUSY: begin
                if (bus.down_resp) begin
                    state_d      = DONE;
                    down_read_d  = 1'b0;
                    down_write_d = 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
                    rr_ptr_d = (grant_id_q == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                     : grant_id_q + 1'b1;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            down_read_q  <= 1'b0;
            down_write_q <= 1'b0;
            down_addr_q  <= '0;
            down_wdata_q <= '0;
`ifdef L2_ARB_ROUND_ROBIN_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            down_read_q  <= down_read_d;
            down_write_q <= down_write_d;
            down_addr_q  <= down_addr_d;
            down_wdata_q <= down_wdata_d;
`ifdef L2_ARB_ROUND_ROBIN_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    // Completion is forwarded combinationally, but only while a transaction is live.
    always_comb begin
        bus.req_resp = '0;
        if (state_q == BUSY && bus.down_resp) begin
            bus.req_resp[grant_id_q] = 1'b1;
        end
    end

    assign bus.req_rdata  = bus.down_rdata;
    assign bus.down_read  = down_read_q;
    assign bus.down_write = down_write_q;
    assign bus.down_addr  = down_addr_q;
    assign bus.down_wdata = down_wdata_q;
    assign bus.grant_id   = grant_id_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed, table-driven bench for l2_arbiter (2 ports); expectations adapt
// to whether L2_ARB_ROUND_ROBIN_EN is defined.
module tb_l2_arbiter;

    localparam int unsigned NP = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

`ifdef L2_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    l2_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) bus ();

    l2_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        resp;
        logic        edr;
        logic        edw;
        logic        egid;
        logic [1:0]  ersp;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_dead;
    logic [LW-1:0] line_11;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] rd, input logic [1:0] wr, input logic resp,
                       input logic edr, input logic edw, input logic egid,
                       input logic [1:0] ersp, input logic [31:0] eaddr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.resp = resp; v.edr = edr; v.edw = edw;
        v.egid = egid; v.ersp = ersp; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    // Waits (bounded) for a downstream request; returns 0 on timeout.
    task automatic wait_down(output bit ok);
        int cyc;
        cyc = 0;
        while (!(bus.down_read || bus.down_write) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = (bus.down_read || bus.down_write);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_down: got no request want request within 20 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [1:0] exp_seq [4];
        logic [1:0] oh;

        checks    = 0;
        errors    = 0;
        line_a5   = {32{8'hA5}};
        line_dead = {16{16'hDEAD}};
        line_11   = {32{8'h11}};

        rst            = 1'b1;
        bus.req_read   = '0;
        bus.req_write  = '0;
        bus.req_addr[0]  = 32'h0000_0040;
        bus.req_addr[1]  = 32'h0000_1000;
        bus.req_wdata[0] = line_11;
        bus.req_wdata[1] = line_dead;
        bus.down_rdata = line_a5;
        bus.down_resp  = 1'b0;

        // rd, wr, resp | down_read, down_write, grant_id, req_resp, down_addr
        add(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);     // single read
        add(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h40);
        add(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h40);
        add(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h40);
        add(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h40);
        add(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 32'h40);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h40);    // stray resp in DONE
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h40);    // stray resp in IDLE
        add(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h40);    // port1 write
        add(2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h1000);
        add(2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 32'h1000);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h1000);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h1000);
        add(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h1000);  // contention
        add(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h40);
        add(2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 32'h40);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h40);
        add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h40);
        add(2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h1000);
        add(2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 32'h1000);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h1000);
        add(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h1000);  // read+write -> write
        add(2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h40);
        add(2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h40);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h40);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_down_read", LW'(bus.down_read), LW'(1'b0));
        chk("rst_down_write", LW'(bus.down_write), LW'(1'b0));
        chk("rst_grant_id", LW'(bus.grant_id), LW'(1'b0));
        chk("rst_down_addr", LW'(bus.down_addr), LW'(0));
        chk("rst_down_wdata", bus.down_wdata, LW'(0));
        chk("rst_req_resp", LW'(bus.req_resp), LW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            bus.req_read  = vecs[k].rd;
            bus.req_write = vecs[k].wr;
            bus.down_resp = vecs[k].resp;
            @(negedge clk);
            chk($sformatf("row%0d_down_read", k), LW'(bus.down_read), LW'(vecs[k].edr));
            chk($sformatf("row%0d_down_write", k), LW'(bus.down_write), LW'(vecs[k].edw));
            chk($sformatf("row%0d_grant_id", k), LW'(bus.grant_id), LW'(vecs[k].egid));
            chk($sformatf("row%0d_req_resp", k), LW'(bus.req_resp), LW'(vecs[k].ersp));
            chk($sformatf("row%0d_down_addr", k), LW'(bus.down_addr), LW'(vecs[k].eaddr));
            if (vecs[k].edw) begin
                chk($sformatf("row%0d_down_wdata", k), bus.down_wdata,
                    vecs[k].egid ? line_dead : line_11);
            end
            if (vecs[k].ersp != 2'b00) begin
                chk($sformatf("row%0d_req_rdata", k), bus.req_rdata, line_a5);
            end
            @(posedge clk);
            #1;
        end
        bus.down_resp = 1'b0;

        // Both ports hold requests continuously across four transactions.
        if (RR) begin
            exp_seq[0] = 2'd1; exp_seq[1] = 2'd0; exp_seq[2] = 2'd1; exp_seq[3] = 2'd0;
        end else begin
            exp_seq[0] = 2'd0; exp_seq[1] = 2'd0; exp_seq[2] = 2'd0; exp_seq[3] = 2'd0;
        end
        bus.req_read = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_down(ok);
            chk($sformatf("starve%0d_grant_id", t), LW'(bus.grant_id), LW'(exp_seq[t][0]));
            bus.down_resp = 1'b1;
            #1;
            oh = 2'b01 << exp_seq[t][0];
            chk($sformatf("starve%0d_req_resp", t), LW'(bus.req_resp), LW'(oh));
            @(posedge clk);
            #1;
            bus.down_resp = 1'b0;
        end

        // Reset two cycles after granting port1.
        bus.req_read = 2'b10;
        wait_down(ok);
        chk("rstmid_grant_id", LW'(bus.grant_id), LW'(1'b1));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.down_resp = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_down_read", LW'(bus.down_read), LW'(1'b0));
        chk("rstmid_grant_id0", LW'(bus.grant_id), LW'(1'b0));
        chk("rstmid_down_addr", LW'(bus.down_addr), LW'(0));
        chk("rstmid_req_resp", LW'(bus.req_resp), LW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_read = 2'b00;
        @(negedge clk);
        chk("postrst_req_resp", LW'(bus.req_resp), LW'(0));
        @(posedge clk);
        #1;
        bus.down_resp = 1'b0;

        // Pointer is back at zero, so port0 wins a tie in either build.
        bus.req_read = 2'b11;
        wait_down(ok);
        chk("postrst_grant_id", LW'(bus.grant_id), LW'(1'b0));
        bus.down_resp = 1'b1;
        #1;
        chk("postrst_txn_resp", LW'(bus.req_resp), LW'(2'b01));
        @(posedge clk);
        #1;
        bus.down_resp = 1'b0;
        bus.req_read  = 2'b00;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
